// File: rtl/mul_operand_feeder_if.sv
// Operand-pair handshake and MUL serial bus between an upstream source and mul_operand_feeder.
// The slave modport is the feeder's view; master is the environment (source plus MUL) side.
interface mul_operand_feeder_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mul_start;
    logic [WIDTH-1:0] mul_data;
    logic             mul_done;

    modport master (
        output op_valid, op_a, op_b, mul_done,
        input  op_ready, mul_start, mul_data
    );

    modport slave (
        input  op_valid, op_a, op_b, mul_done,
        output op_ready, mul_start, mul_data
    );
endinterface

// File: rtl/mul_operand_feeder.sv
// Sequences one (A, B) operand pair onto the MUL serial interface and waits for done.
// Optional watchdog on the done wait: define MUL_FEED_TIMEOUT_EN.
module mul_operand_feeder #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 70000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    mul_operand_feeder_if.slave      bus,
    output logic                     busy,
    output logic                     complete,
    output logic                     timeout_err
);

    if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cfg
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StWaitDone} state_e;

    state_e           state_q;
    logic             op_ready_q;
    logic             mul_start_q;
    logic [WIDTH-1:0] mul_data_q;
    logic [WIDTH-1:0] b_q;
    logic             busy_q;
    logic             complete_q;

`ifdef MUL_FEED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_ready_q  <= 1'b1;
            mul_start_q <= 1'b0;
            mul_data_q  <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
`ifdef MUL_FEED_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.op_valid && op_ready_q) begin
                        // A goes straight onto the bus; only B needs to be kept.
                        b_q         <= bus.op_b;
                        mul_data_q  <= bus.op_a;
                        mul_start_q <= 1'b1;
                        op_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StLoadA;
                    end
                end
                StLoadA: begin
                    mul_data_q <= b_q;
                    state_q    <= StLoadB;
                end
                StLoadB: begin
`ifdef MUL_FEED_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (bus.mul_done) begin
                        complete_q  <= 1'b1;
                        mul_start_q <= 1'b0;
                        mul_data_q  <= '0;
                        op_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
`ifdef MUL_FEED_TIMEOUT_EN
                    // Done has priority over the terminal count.
                    else if (cnt_q == CntLast) begin
                        timeout_err_q <= 1'b1;
                        mul_start_q   <= 1'b0;
                        mul_data_q    <= '0;
                        op_ready_q    <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.op_ready  = op_ready_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_data  = mul_data_q;
    assign busy          = busy_q;
    assign complete      = complete_q;

`ifdef MUL_FEED_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Directed bench for mul_operand_feeder: a transaction-level model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_mul_operand_feeder;
    localparam int unsigned W  = 16;
    localparam int unsigned TO = 10;

    logic clk = 1'b0;
    logic rst;
    logic busy, complete, timeout_err;

    mul_operand_feeder_if #(.WIDTH(W)) bus ();

    mul_operand_feeder #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (17)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .complete    (complete),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: phase = edges since accept (-1 when idle), wait = cycles spent waiting for done.
    int           m_phase = -1;
    int           m_wait  = 0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    bit           m_cmp   = 1'b0;
    bit           m_err   = 1'b0;
    bit           m_on    = 1'b0;

    always @(posedge clk) begin
        m_cmp <= 1'b0;
        if (rst) begin
            m_on    <= 1'b1;
            m_phase <= -1;
            m_a     <= '0;
            m_b     <= '0;
            m_wait  <= 0;
            m_err   <= 1'b0;
        end else if (m_phase < 0) begin
            if (bus.op_valid) begin
                m_phase <= 0;
                m_a     <= bus.op_a;
                m_b     <= bus.op_b;
            end
        end else if (m_phase < 2) begin
            m_phase <= m_phase + 1;
            m_wait  <= 0;
        end else if (bus.mul_done) begin
            m_phase <= -1;
            m_cmp   <= 1'b1;
        end
`ifdef MUL_FEED_TIMEOUT_EN
        else if (m_wait == int'(TO) - 1) begin
            m_phase <= -1;
            m_err   <= 1'b1;
        end
`endif
        else begin
            m_wait <= m_wait + 1;
        end
    end

    logic [W-1:0] exp_data;
    bit           exp_idle;

    always @(negedge clk) begin
        if (m_on) begin
            exp_idle = (m_phase < 0);
            exp_data = exp_idle ? '0 : ((m_phase == 0) ? m_a : m_b);
            check("model op_ready",    32'(bus.op_ready),  32'(exp_idle));
            check("model busy",        32'(busy),          32'(!exp_idle));
            check("model mul_start",   32'(bus.mul_start), 32'(!exp_idle));
            check("model mul_data",    32'(bus.mul_data),  32'(exp_data));
            check("model complete",    32'(complete),      32'(m_cmp));
            check("model timeout_err", 32'(timeout_err),   32'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a pair for one edge, then scramble the inputs to prove they were captured.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        tick();
        bus.op_valid = 1'b0;
        bus.op_a     = 16'hdead;
        bus.op_b     = 16'hbeef;
    endtask

    int n;

    initial begin
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.mul_done = 1'b0;
        tick();
        tick();
        check("reset op_ready",    32'(bus.op_ready),  1);
        check("reset mul_start",   32'(bus.mul_start), 0);
        check("reset mul_data",    32'(bus.mul_data),  0);
        check("reset busy",        32'(busy),          0);
        check("reset timeout_err", 32'(timeout_err),   0);
        rst = 1'b0;
        tick();

        // 1: single pair (15,15)
        send(16'd15, 16'd15);
        check("t1 op_ready low", 32'(bus.op_ready),  0);
        check("t1 start",        32'(bus.mul_start), 1);
        check("t1 data A",       32'(bus.mul_data),  15);
        tick();
        check("t1 data B",       32'(bus.mul_data),  15);
        repeat (4) tick();
        check("t1 data held",    32'(bus.mul_data),  15);
        check("t1 busy held",    32'(busy),          1);
        bus.mul_done = 1'b1;
        tick();
        check("t1 complete",     32'(complete),      1);
        check("t1 start drop",   32'(bus.mul_start), 0);
        check("t1 data zero",    32'(bus.mul_data),  0);
        check("t1 op_ready",     32'(bus.op_ready),  1);
        bus.mul_done = 1'b0;
        tick();
        check("t1 complete one", 32'(complete),      0);

        // 2: back-to-back (15,5) then (7,3), op_valid held
        bus.op_valid = 1'b1;
        bus.op_a     = 16'd15;
        bus.op_b     = 16'd5;
        bus.mul_done = 1'b1;
        tick();
        check("t2 p1 A", 32'(bus.mul_data), 15);
        bus.op_a = 16'd7;
        bus.op_b = 16'd3;
        tick();
        check("t2 p1 B", 32'(bus.mul_data), 5);
        tick();
        tick();
        check("t2 p1 complete", 32'(complete),     1);
        check("t2 p1 ready",    32'(bus.op_ready), 1);
        tick();
        check("t2 p2 A",        32'(bus.mul_data), 7);
        check("t2 p2 no cmp",   32'(complete),     0);
        bus.op_valid = 1'b0;
        tick();
        check("t2 p2 B",        32'(bus.mul_data), 3);
        tick();
        tick();
        check("t2 p2 complete", 32'(complete),     1);
        bus.mul_done = 1'b0;
        tick();
        check("t2 idle after",  32'(busy),         0);

        // 3: done high during the load cycles is ignored
        bus.mul_done = 1'b1;
        send(16'd21, 16'd2);
        check("t3 no cmp A", 32'(complete), 0);
        tick();
        check("t3 no cmp B", 32'(complete), 0);
        tick();
        check("t3 no cmp W", 32'(complete), 0);
        check("t3 busy W",   32'(busy),     1);
        tick();
        check("t3 complete 3rd edge", 32'(complete), 1);
        bus.mul_done = 1'b0;
        tick();

        // 4: reset in the done wait, then (2,3)
        send(16'd9, 16'd4);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t4 rst op_ready",  32'(bus.op_ready),  1);
        check("t4 rst start",     32'(bus.mul_start), 0);
        check("t4 rst data",      32'(bus.mul_data),  0);
        check("t4 rst busy",      32'(busy),          0);
        check("t4 rst no cmp",    32'(complete),      0);
        rst = 1'b0;
        tick();
        send(16'd2, 16'd3);
        check("t4 data A", 32'(bus.mul_data), 2);
        tick();
        check("t4 data B", 32'(bus.mul_data), 3);
        tick();
        bus.mul_done = 1'b1;
        tick();
        check("t4 complete", 32'(complete), 1);
        bus.mul_done = 1'b0;
        tick();

        // 5: done never arrives
        send(16'd1, 16'd1);
`ifdef MUL_FEED_TIMEOUT_EN
        n = 0;
        while (bus.op_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("t5 edges to abort", 32'(n),           12);
        check("t5 timeout_err",    32'(timeout_err), 1);
        check("t5 no complete",    32'(complete),    0);
        check("t5 start drop",     32'(bus.mul_start), 0);
        tick();
        check("t5 err sticky",     32'(timeout_err), 1);
`else
        repeat (1000) tick();
        check("t5 still busy",  32'(busy),          1);
        check("t5 still start", 32'(bus.mul_start), 1);
        check("t5 data held",   32'(bus.mul_data),  1);
        check("t5 no err",      32'(timeout_err),   0);
        bus.mul_done = 1'b1;
        tick();
        check("t5 late complete", 32'(complete), 1);
        bus.mul_done = 1'b0;
        tick();
`endif

        // 6: done arrives on the terminal-count cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send(16'd3, 16'd5);
        repeat (11) tick();
        check("t6 busy at terminal", 32'(busy), 1);
        bus.mul_done = 1'b1;
        tick();
        check("t6 complete",   32'(complete),     1);
        check("t6 no err",     32'(timeout_err),  0);
        check("t6 op_ready",   32'(bus.op_ready), 1);
        bus.mul_done = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_operand_feeder.md
Name: mul_operand_feeder

Overview:
Upstream sequencer for the MUL datapath/controller multiplier. Accepts one operand pair (A, B) over a valid/ready handshake, then drives MUL's serial interface: start, then A on data_in for one cycle, then B. It holds the bus stable until MUL raises done, reports completion, and returns to idle for the next pair.

Parameters:
WIDTH, 16, operand and data_in bus width; must match MUL data_in.
TIMEOUT_CYCLES, 70000, maximum WAIT_DONE cycles before abort; must exceed the worst-case MUL iteration count of 2^WIDTH-1.
CNT_W, 17, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
op_valid  in  1  operand pair present
op_ready  out  1  feeder can accept a pair
op_a  in  WIDTH  multiplicand, first word sent
op_b  in  WIDTH  multiplier, second word sent
mul_start  out  1  to MUL start
mul_data  out  WIDTH  to MUL data_in
mul_done  in  1  from MUL done
busy  out  1  transaction in flight
complete  out  1  one-cycle pulse when MUL done is seen
timeout_err  out  1  sticky, set on watchdog abort (see Optional Feature)

Behaviour:
- Reset values, applied on any clk edge with rst=1 regardless of state: state=IDLE, op_ready=1, mul_start=0, mul_data=0, busy=0, complete=0, timeout_err=0, counter=0, operand registers=0.
- op_ready=1 only in IDLE. Accept occurs on an edge where op_valid & op_ready; op_a and op_b are captured into internal registers at that edge. The inputs may change afterwards.
- FSM states and transitions:
  - IDLE: on accept, go to LOAD_A.
  - LOAD_A, 1 cycle: mul_start=1, mul_data=A_reg. Go to LOAD_B.
  - LOAD_B, 1 cycle: mul_start=1, mul_data=B_reg. Go to WAIT_DONE.
  - WAIT_DONE: mul_start=1, mul_data held at B_reg. When mul_done=1 is sampled, go to IDLE.
- Outputs are registered. The first edge after accept shows mul_start=1 and mul_data=A. The following edge shows B.
- complete pulses exactly 1 cycle, registered on the edge that leaves WAIT_DONE. On that same edge mul_start drops to 0, mul_data returns to 0, and op_ready rises to 1.
- busy=1 in LOAD_A, LOAD_B and WAIT_DONE.
- Minimum turnaround: with mul_done already high, accept to complete is 3 edges. A new accept is possible on the edge after complete.
- mul_done during LOAD_A or LOAD_B is ignored, because MUL has not finished loading. Only mul_done sampled in WAIT_DONE counts.
- op_valid while busy: the pair is not accepted and no state changes. The upstream source must hold the pair.
- Zero operands are forwarded unchanged; MUL handles them.
- rst mid-transaction: the transaction is aborted with no complete pulse, and mul_start drops on the reset edge.

Optional Feature:
Macro MUL_FEED_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to WAIT_DONE and increments each cycle while there.
  - When the counter reaches TIMEOUT_CYCLES-1 without mul_done: go to IDLE, drop mul_start, set timeout_err=1, and do not pulse complete.
  - timeout_err stays set until rst.
  - If mul_done and the terminal count coincide, done wins: complete pulses and timeout_err is not set.
- Not defined: no counter logic. WAIT_DONE waits indefinitely and timeout_err is tied to 0.

Test Plan:
1. Reset, then op_a=15, op_b=15, op_valid=1 for one cycle -> op_ready falls. Next edge: mul_start=1, mul_data=15. Next edge: mul_data=15. Then data holds until mul_done. Raise mul_done -> complete pulses 1 cycle, mul_start=0, op_ready=1.
2. Back-to-back pairs (15,5) then (7,3) with op_valid held high -> the second pair is accepted on the edge after complete. mul_data sequence is 15,5 then 7,3, and no pair is lost or duplicated.
3. mul_done=1 forced during LOAD_A and LOAD_B -> no early exit. complete occurs on the 3rd edge after accept.
4. rst=1 asserted in WAIT_DONE -> on the next edge all outputs are at reset values, with no complete pulse. A new pair (2,3) then sequences normally.
5. With MUL_FEED_TIMEOUT_EN, TIMEOUT_CYCLES=10 and mul_done held 0 -> 10 WAIT_DONE cycles, then IDLE with timeout_err=1 and no complete. Without the macro the feeder stays in WAIT_DONE for 1000 cycles.
6. With MUL_FEED_TIMEOUT_EN, mul_done raised on the terminal-count cycle -> complete=1 and timeout_err stays 0.
